// File: rtl/encoder_pulse_gen.sv
// encoder_pulse_gen
//   Encoder pulse emulator. Each measurement window it emits exactly the
//   requested number of evenly spaced pulses on A. It uses the same
//   prescaler/tick window timing as the windowed encoder pulse counter:
//   W = CLK_DIV * WINDOW_TICKS clocks per window.
//
// Parameters
//   CLK_DIV      clocks per tick
//   WINDOW_TICKS ticks per window
//   PULSE_HIGH   clocks A stays high per pulse (needs W/255 >= 2*PULSE_HIGH)
//
// Ports
//   CLK      clock, rising edge
//   RST      asynchronous reset, active low
//   Count_in requested pulses per window (0..255), qualified by Load
//   Load     one-cycle qualifier for Count_in
//   A        registered pulse output
//   En       one-cycle strobe on the first cycle of each window
//   Sent     pulses fired in the previous window
//   Busy     high while windows are running
module encoder_pulse_gen #(
  parameter int unsigned CLK_DIV      = 3200,
  parameter int unsigned WINDOW_TICKS = 21,
  parameter int unsigned PULSE_HIGH   = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] Count_in,
  input  logic       Load,
  output logic       A,
  output logic       En,
  output logic [7:0] Sent,
  output logic       Busy
);

  localparam int unsigned W     = CLK_DIV * WINDOW_TICKS;
  localparam int unsigned PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TW    = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam int unsigned HW    = (PULSE_HIGH > 1) ? $clog2(PULSE_HIGH) : 1;
  localparam int unsigned ACC_W = $clog2(W + 256);

  localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0]    TICK_MAX  = TW'(WINDOW_TICKS - 1);
  localparam logic [ACC_W-1:0] W_L       = ACC_W'(W);
  localparam logic [ACC_W-1:0] HALF_W    = ACC_W'(W / 2);
  localparam logic [HW-1:0]    WID_INIT  = HW'(PULSE_HIGH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       active_q, active_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [7:0]       sent_cnt_q, sent_cnt_d;
  logic [7:0]       sent_q, sent_d;
  logic             en_q, en_d;
  logic             a_q, a_d;
  logic [HW-1:0]    wid_q, wid_d;

  logic             fire;
  logic             boundary;
  logic [ACC_W-1:0] sum;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tick_d     = tick_q;
    acc_d      = acc_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    sent_cnt_d = sent_cnt_q;
    sent_d     = sent_q;
    en_d       = 1'b0;
    a_d        = a_q;
    wid_d      = wid_q;
    fire       = 1'b0;
    boundary   = 1'b0;
    sum        = acc_q + ACC_W'(active_q);

    case (state_q)
      IDLE: begin
        if (Load) begin
          state_d  = RUN;
          presc_d  = '0;
          tick_d   = '0;
          acc_d    = HALF_W;
          active_d = Count_in;
          en_d     = 1'b1;
        end
      end

      RUN: begin
        boundary = (presc_q == PRESC_MAX) && (tick_q == TICK_MAX);

        // Bresenham: acc stays below W, so sum < W + 256 never overflows.
        if (sum >= W_L) begin
          acc_d = sum - W_L;
          fire  = 1'b1;
        end else begin
          acc_d = sum;
        end

        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          tick_d  = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end

        if (Load) begin
          pend_d     = Count_in;
          pend_vld_d = 1'b1;
        end

        if (boundary) begin
          en_d       = 1'b1;
          sent_d     = sent_cnt_q + {7'd0, fire};
          sent_cnt_d = '0;
          pend_vld_d = 1'b0;
          // A Load landing on the boundary cycle bypasses the pending
          // register so it still governs the window that starts next.
          if (Load) begin
            active_d = Count_in;
          end else if (pend_vld_q) begin
            active_d = pend_q;
          end
        end else begin
          sent_cnt_d = sent_cnt_q + {7'd0, fire};
        end
      end

      default: state_d = IDLE;
    endcase

    // Pulse shaper: width counter counts down the remaining high cycles.
    if (fire) begin
      a_d   = 1'b1;
      wid_d = WID_INIT;
    end else if (a_q) begin
      if (wid_q == '0) begin
        a_d = 1'b0;
      end else begin
        wid_d = wid_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tick_q     <= '0;
      acc_q      <= '0;
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      sent_cnt_q <= '0;
      sent_q     <= '0;
      en_q       <= 1'b0;
      a_q        <= 1'b0;
      wid_q      <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      acc_q      <= acc_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      sent_cnt_q <= sent_cnt_d;
      sent_q     <= sent_d;
      en_q       <= en_d;
      a_q        <= a_d;
      wid_q      <= wid_d;
    end
  end

  assign A    = a_q;
  assign En   = en_q;
  assign Sent = sent_q;
  assign Busy = (state_q == RUN);

endmodule

// File: tb/tb_encoder_pulse_gen.sv
module tb_encoder_pulse_gen;

  // W = 40 * 30 = 1200, PULSE_HIGH = 2: legal since 1200/255 = 4 >= 4.
  localparam int W  = 1200;
  localparam int PH = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] Count_in;
  logic       Load;
  logic       A;
  logic       En;
  logic [7:0] Sent;
  logic       Busy;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int rises[$];
  int falls[$];
  int ens[$];
  bit a_prev = 1'b0;

  encoder_pulse_gen #(
    .CLK_DIV     (40),
    .WINDOW_TICKS(30),
    .PULSE_HIGH  (PH)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Count_in(Count_in),
    .Load    (Load),
    .A       (A),
    .En      (En),
    .Sent    (Sent),
    .Busy    (Busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record event cycles; the directed sequence inspects these afterwards.
  always @(negedge CLK) begin
    if (A === 1'b1 && !a_prev) rises.push_back(cyc);
    if (A !== 1'b1 && a_prev)  falls.push_back(cyc);
    if (En === 1'b1)           ens.push_back(cyc);
    a_prev = (A === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  function automatic int count_rises(input int lo, input int hi);
    int n = 0;
    foreach (rises[j]) if (rises[j] >= lo && rises[j] < hi) n++;
    return n;
  endfunction

  function automatic int first_rise(input int lo);
    foreach (rises[j]) if (rises[j] >= lo) return rises[j];
    return -1;
  endfunction

  initial begin
    int e0, w2, w3, w4, w5, w6;
    int nr, ne, bad_sp, bad_wid, bad_rng, bad_per, idx;

    RST = 1'b0; Load = 1'b0; Count_in = 8'd0;
    tick(3);
    check("rst_A", A, 0);
    check("rst_En", En, 0);
    check("rst_Sent", Sent, 0);
    check("rst_Busy", Busy, 0);

    // Idle for 2W with Count_in wiggling but no Load.
    RST = 1'b1;
    Count_in = 8'd77;  tick(W);
    Count_in = 8'd200; tick(W);
    check("idle_rises", rises.size(), 0);
    check("idle_ens", ens.size(), 0);
    check("idle_Sent", Sent, 0);
    check("idle_Busy", Busy, 0);
    check("idle_A", A, 0);

    // Load 10 from IDLE; En must appear in the very next cycle.
    Count_in = 8'd10; Load = 1'b1;
    tick(1);
    Load = 1'b0; Count_in = 8'd99;
    e0 = cyc;
    check("w1_En", En, 1);
    check("w1_Busy", Busy, 1);
    check("w1_Sent", Sent, 0);
    tick(1);
    check("w1_En_one_cycle", En, 0);
    tick(W - 1);

    w2 = e0 + W;
    check("w2_En", En, 1);
    check("w2_Sent", Sent, 10);
    check("w1_count", count_rises(e0, w2), 10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("w1_rise%0d", k), rises[k], e0 + 60 + 120 * k);
      check($sformatf("w1_width%0d", k), falls[k] - rises[k], PH);
    end

    // Load 255 during RUN: takes effect at the next window start.
    Count_in = 8'd255; Load = 1'b1;
    tick(1);
    Load = 1'b0;
    tick(W - 1);
    w3 = w2 + W;
    check("w3_En", En, 1);
    check("w3_Sent", Sent, 10);
    check("w2_count", count_rises(w2, w3), 10);

    Count_in = 8'd0; Load = 1'b1;
    tick(1);
    Load = 1'b0;
    tick(W - 1);
    w4 = w3 + W;
    check("w4_Sent", Sent, 255);
    check("w3_count", count_rises(w3, w4), 255);
    bad_sp = 0; bad_wid = 0; bad_rng = 0;
    foreach (rises[j]) begin
      if (rises[j] >= w3 && rises[j] < w4) begin
        idx = rises[j] - w3;
        if (idx < 1 || idx > W - 1) bad_rng++;
        if (falls[j] - rises[j] != PH) bad_wid++;
        if (j > 0 && rises[j - 1] >= w3) begin
          if (rises[j] - rises[j - 1] != 4 && rises[j] - rises[j - 1] != 5) bad_sp++;
        end
      end
    end
    check("w3_spacing_bad", bad_sp, 0);
    check("w3_width_bad", bad_wid, 0);
    check("w3_range_bad", bad_rng, 0);

    // Window 4 runs at 0; queue 20 for window 5.
    Count_in = 8'd20; Load = 1'b1;
    tick(1);
    Load = 1'b0;
    tick(W - 1);
    w5 = w4 + W;
    check("w5_Sent", Sent, 0);
    check("w4_count", count_rises(w4, w5), 0);

    // Window 5 at 20: Load 40 at index 1000, then 30 on the boundary index.
    tick(1000);
    Count_in = 8'd40; Load = 1'b1;
    tick(1);
    Load = 1'b0;
    tick(198);
    Count_in = 8'd30; Load = 1'b1;
    tick(1);
    Load = 1'b0;
    w6 = w5 + W;
    check("w6_En", En, 1);
    check("w6_Sent", Sent, 20);
    check("w5_count", count_rises(w5, w6), 20);
    check("w5_first_rise", first_rise(w5), w5 + 30);

    // Window 6 at 30: first pulse high at index 20..21; reset mid-pulse.
    tick(20);
    check("w6_A_high", A, 1);
    check("w6_first_rise", first_rise(w6), w6 + 20);
    RST = 1'b0;
    #1;
    check("async_A", A, 0);
    check("async_En", En, 0);
    check("async_Sent", Sent, 0);
    check("async_Busy", Busy, 0);

    bad_per = 0;
    for (int j = 1; j < ens.size(); j++) if (ens[j] - ens[j - 1] != W) bad_per++;
    check("en_count", ens.size(), 6);
    check("en_period_bad", bad_per, 0);

    tick(2);
    RST = 1'b1;
    nr = rises.size();
    ne = ens.size();
    Count_in = 8'd50;
    tick(W + 100);
    check("post_rst_rises", rises.size(), nr);
    check("post_rst_ens", ens.size(), ne);
    check("post_rst_Busy", Busy, 0);
    check("post_rst_A", A, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_pulse_gen.md
# encoder_pulse_gen

Encoder pulse emulator: the transmit-side counterpart of the windowed encoder pulse counter. Each measurement window it emits exactly the requested number of evenly spaced pulses on `A`, which drives a counter's `A` input in loopback benches and on the bring-up board. Window timing uses the same prescaler/tick scheme as the counter: `CLK_DIV` clocks per tick and `WINDOW_TICKS` ticks per window. A one-cycle `En` strobe marks each window start.

## Interface
- `CLK_DIV`, default 3200: CLK cycles per tick.
- `WINDOW_TICKS`, default 21: ticks per window. The window length is W = `CLK_DIV`*`WINDOW_TICKS` (67200 by default).
- `PULSE_HIGH`, default 8: CLK cycles `A` stays high per pulse. Legal only if W/255 >= 2*`PULSE_HIGH`.
- `CLK` in 1: the single clock. All logic is on its rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `Count_in` in 8: requested pulses per window, 0..255.
- `Load` in 1: a one-cycle qualifier for `Count_in`.
- `A` out 1: pulse output, registered.
- `En` out 1: one-cycle strobe on the first cycle of each window.
- `Sent` out 8: number of pulses fired in the previous window.
- `Busy` out 1: high in RUN.

## Operation
- States:
  - IDLE: counters held at 0, `A`=0.
  - RUN: windows repeat back-to-back.
- IDLE→RUN: `Load`=1 at cycle t.
  - At t+1: `En`=1, active=`Count_in`(t), the window starts at cycle index 0, and acc=floor(W/2).
- RUN→IDLE: only via reset.
- Window counters:
  - The prescaler runs 0..`CLK_DIV`-1.
  - The tick counter advances on prescaler wrap and runs 0..`WINDOW_TICKS`-1.
  - The boundary is the cycle where both are at max (window index W-1).
- Load in RUN:
  - `Load`=1 writes the pending register. Last write before the boundary wins.
  - A `Load` in the boundary cycle itself counts for the next window.
  - At the boundary, active←pending if pending valid, else active is kept. Pending valid is cleared.
- Accumulator (Bresenham), every RUN cycle:
  - s = acc + active.
  - If s >= W: acc←s-W and fire; else acc←s.
  - Width is clog2(W+256) bits, unsigned. No overflow is allowed.
- Exactly `active` fires per window, centred in their intervals. active=0 means no fires.
- Fire at index i: `A` rises at i+1 and stays high `PULSE_HIGH` cycles via a width counter.
- The parameter rule guarantees a pulse always ends before the next fire. No fire is ever dropped or merged.
- Sent counter:
  - Increments per fire and clears at window start.
  - Copied to `Sent` on the boundary edge, so the new value is visible in the `En` cycle.
- `Count_in` changes without `Load` are ignored.

## Timing
- Reset (`RST`=0, async):
  - `A`=0, `En`=0, `Sent`=0, `Busy`=0.
  - acc, counters, active and pending are cleared. State is IDLE.
  - This applies mid-pulse too: `A` drops immediately.
- After `RST` rises, nothing happens until a `Load`.
- Latency:
  - `Load` in IDLE to `En` is 1 cycle.
  - A `Load` in RUN takes effect at the next window start.
- `En` period is exactly W cycles, with no gaps between windows.
- N=10, W=67200:
  - Fires at indices 3359 + 6720k, k=0..9.
  - `A` high at indices 3360..3367, 10080..10087, …, 63840..63847.
- All rising edges of `A` fall within [index 1, index W-1] of the same window for any N 1..255.

## Test plan
- Reset, then hold `Load`=0 for 2W cycles → `A`=0, `En` never pulses, `Sent`=0, `Busy`=0.
- `Load` with 10 at cycle t:
  - `En` at t+1.
  - Exactly 10 `A` rising edges, at t+1+3360+6720k, each high 8 cycles.
  - Next `En` at t+1+67200 with `Sent`=10.
- `Count_in`=255:
  - 255 rising edges per window, with spacing 263 or 264 cycles.
  - `A` is never high more than 8 cycles consecutively; `Sent`=255.
  - A loopback counter driven by `A`, with its window aligned to `En`, reads 255.
- `Count_in`=0 → `A` stays 0 for the full window; `Sent`=0.
- Running at 20:
  - `Load` 40 at index 1000, then `Load` 30 at index 67199.
  - Current window still emits 20; the next window emits 30.
- Reset asserted during a high `A` pulse mid-window → `A`, `En`, `Sent` and `Busy` go to 0 without a clock edge. After release, no pulses until a new `Load`.
